// File: rtl/osc_tick_gen.sv
// osc_tick_gen -- multi-channel programmable clock-enable generator.
//
// Each channel divides clk by its active ratio and emits a one-cycle tick
// per divided period plus a square wave that toggles on every tick.
// New ratios are staged via div_wr and applied only at a period boundary
// (wrap), on sync, or immediately when the channel is idle, so a running
// channel never produces a truncated period.
//
// Parameters:
//   CH      - number of independent divider channels (1..16)
//   CNT_W   - counter / ratio width in bits
//   DEF_DIV - ratio loaded into every channel at reset
//
// Ports:
//   clk     - single clock (normally the on-chip oscillator)
//   rst_n   - asynchronous active-low reset, released synchronously upstream
//   en      - per-channel run enable
//   sync    - one-cycle pulse that phase-aligns all channels
//   div_wr  - one-cycle ratio write strobe
//   div_sel - target channel of the write (out-of-range writes are ignored)
//   div_val - new divide ratio
//   div_ack - per-channel one-cycle pulse, the cycle after a staged ratio applies
//   tick    - per-channel one-cycle clock-enable pulse per divided period
//   sq      - per-channel square wave, period 2*div
module osc_tick_gen #(
    parameter int CH      = 4,
    parameter int CNT_W   = 24,
    parameter int DEF_DIV = 100,
    localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    en,
    input  logic             sync,
    input  logic             div_wr,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [CH-1:0]    div_ack,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    sq
);

    localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [SEL_W:0]   CH_V  = (SEL_W + 1)'(CH);

    // Writes addressing a non-existent channel must not touch any state.
    logic sel_ok;
    assign sel_ok = ({1'b0, div_sel} < CH_V);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] stg_q, stg_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             ack_q, ack_d;
        logic             wr_hit, running, wrap, apply;

        always_comb begin
            wr_hit  = div_wr && sel_ok && (div_sel == IDX);
            running = en[i] && (div_q != '0);
            wrap    = running && (cnt_q == div_q - ONE);
            // A pending ratio lands on a period boundary (wrap or sync), or
            // straight away when the channel is not counting.
            apply   = pend_q && (wrap || sync || !running);

            cnt_d  = cnt_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            if (!en[i]) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (sync) begin
                // Sync outranks a coincident wrap: no tick this cycle.
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (div_q == '0) begin
                cnt_d = '0;
            end else if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + ONE;
            end
            if (sync) begin
                sq_d = 1'b0;
            end

            div_d = apply ? stg_q : div_q;
            stg_d = wr_hit ? div_val : stg_q;
            // A write landing on the apply edge re-arms pending for the new value.
            pend_d = wr_hit ? 1'b1 : (apply ? 1'b0 : pend_q);
            ack_d  = apply;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                div_q  <= DEF_V;
                stg_q  <= DEF_V;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                ack_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                stg_q  <= stg_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
                ack_q  <= ack_d;
            end
        end

        assign tick[i]    = tick_q;
        assign sq[i]      = sq_q;
        assign div_ack[i] = ack_q;
    end

endmodule

// File: tb/tb_osc_tick_gen.sv
module tb_osc_tick_gen;

    logic        clk;
    logic        rst_n;
    logic [3:0]  en;
    logic        sync;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [23:0] div_val;
    logic [3:0]  div_ack;
    logic [3:0]  tick;
    logic [3:0]  sq;

    int n_chk  = 0;
    int n_fail = 0;
    int acks;

    osc_tick_gen #(.CH(4), .CNT_W(24), .DEF_DIV(100)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .div_wr  (div_wr),
        .div_sel (div_sel),
        .div_val (div_val),
        .div_ack (div_ack),
        .tick    (tick),
        .sq      (sq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_acks(input int n);
        for (int k = 0; k < n; k++) begin
            wait_edges(1);
            acks += $countones(div_ack);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 4'b0000; sync = 1'b0;
        div_wr = 1'b0; div_sel = 2'd0; div_val = '0;

        // Reset state
        wait_edges(1);                       // e0
        chk("reset_tick", {28'd0, tick}, 32'h0);
        chk("reset_sq",   {28'd0, sq}, 32'h0);
        chk("reset_ack",  {28'd0, div_ack}, 32'h0);
        rst_n = 1'b1; en = 4'b0001;

        // Default divide by 100 on ch0
        wait_edges(99);                      // e99
        chk("def_tick_before", {28'd0, tick}, 32'h0);
        wait_edges(1);                       // e100
        chk("def_tick_first", {28'd0, tick}, 32'h1);
        chk("def_sq_first",   {28'd0, sq}, 32'h1);
        wait_edges(1);                       // e101
        chk("def_tick_one_cycle", {28'd0, tick}, 32'h0);
        wait_edges(99);                      // e200
        chk("def_tick_second", {28'd0, tick}, 32'h1);
        chk("def_sq_second",   {28'd0, sq}, 32'h0);

        // Ratio change at cnt=40 waits for the old period to finish
        wait_edges(40);                      // e240, cnt=40
        div_wr = 1'b1; div_sel = 2'd0; div_val = 24'd10;
        wait_edges(1);                       // e241
        div_wr = 1'b0;
        chk("wr10_no_early_ack", {28'd0, div_ack}, 32'h0);
        wait_edges(58);                      // e299
        chk("wr10_old_tick_pending", {28'd0, tick}, 32'h0);
        wait_edges(1);                       // e300
        chk("wr10_old_period_tick", {28'd0, tick}, 32'h1);
        chk("wr10_ack", {28'd0, div_ack}, 32'h1);
        wait_edges(1);                       // e301
        chk("wr10_ack_one_cycle", {28'd0, div_ack}, 32'h0);
        wait_edges(8);                       // e309
        chk("wr10_tick_before", {28'd0, tick}, 32'h0);
        wait_edges(1);                       // e310
        chk("wr10_tick_new", {28'd0, tick}, 32'h1);

        // Two writes before wrap: last one wins, one ack
        wait_edges(1);                       // e311
        div_wr = 1'b1; div_val = 24'd5;
        wait_edges(1);                       // e312
        div_wr = 1'b0;
        wait_edges(1);                       // e313
        div_wr = 1'b1; div_val = 24'd7;
        wait_edges(1);                       // e314
        div_wr = 1'b0;
        acks = 0;
        count_acks(5);                       // e315..e319
        chk("dbl_tick_e319", {28'd0, tick}, 32'h0);
        count_acks(1);                       // e320
        chk("dbl_tick_wrap", {28'd0, tick}, 32'h1);
        count_acks(6);                       // e326
        chk("dbl_tick_e326", {28'd0, tick}, 32'h0);
        count_acks(1);                       // e327
        chk("dbl_tick_div7", {28'd0, tick}, 32'h1);
        count_acks(7);                       // e334
        chk("dbl_tick_div7_again", {28'd0, tick}, 32'h1);
        chk("dbl_ack_count", acks, 32'd1);

        // div=1 on disabled ch1 applies at the next edge
        div_wr = 1'b1; div_sel = 2'd1; div_val = 24'd1;
        wait_edges(1);                       // e335
        div_wr = 1'b0;
        chk("div1_ack_wait", {28'd0, div_ack}, 32'h0);
        wait_edges(1);                       // e336
        chk("div1_ack_idle", {28'd0, div_ack}, 32'h2);
        en = 4'b0011;
        wait_edges(1);                       // e337
        chk("div1_tick_a", {31'd0, tick[1]}, 32'h1);
        chk("div1_sq_a",   {31'd0, sq[1]}, 32'h1);
        wait_edges(1);                       // e338
        chk("div1_tick_b", {31'd0, tick[1]}, 32'h1);
        chk("div1_sq_b",   {31'd0, sq[1]}, 32'h0);
        wait_edges(1);                       // e339
        chk("div1_sq_c",   {31'd0, sq[1]}, 32'h1);

        // div=0 stops ch1 with sq frozen
        div_wr = 1'b1; div_sel = 2'd1; div_val = 24'd0;
        wait_edges(1);                       // e340
        div_wr = 1'b0;
        wait_edges(1);                       // e341
        chk("div0_ack", {28'd0, div_ack}, 32'h2);
        chk("div0_last_sq", {31'd0, sq[1]}, 32'h1);
        wait_edges(1);                       // e342
        chk("div0_tick", {31'd0, tick[1]}, 32'h0);
        wait_edges(3);                       // e345
        chk("div0_tick_hold", {31'd0, tick[1]}, 32'h0);
        chk("div0_sq_hold",   {31'd0, sq[1]}, 32'h1);

        // Ratios 3 (ch0, at its wrap) and 6 (idle ch2), then sync
        div_wr = 1'b1; div_sel = 2'd0; div_val = 24'd3;
        wait_edges(1);                       // e346
        div_sel = 2'd2; div_val = 24'd6;
        wait_edges(1);                       // e347
        div_wr = 1'b0;
        wait_edges(1);                       // e348: ch0 wraps, ch2 idle
        chk("sync_setup_ack", {28'd0, div_ack}, 32'h5);
        en = 4'b0111; sync = 1'b1;
        wait_edges(1);                       // e349
        sync = 1'b0;
        chk("sync_sq_clear", {28'd0, sq}, 32'h0);
        chk("sync_no_tick",  {28'd0, tick}, 32'h0);
        wait_edges(3);                       // e352
        chk("sync_tick3",  {28'd0, tick}, 32'h1);
        chk("sync_sq3",    {28'd0, sq}, 32'h1);
        wait_edges(2);                       // e354
        chk("sync_tick_gap", {28'd0, tick}, 32'h0);
        wait_edges(1);                       // e355
        chk("sync_tick6", {28'd0, tick}, 32'h5);
        chk("sync_sq6",   {28'd0, sq}, 32'h4);

        // en[2] off then on
        en = 4'b0011;
        wait_edges(1);                       // e356
        chk("en_off_tick", {31'd0, tick[2]}, 32'h0);
        chk("en_off_sq",   {31'd0, sq[2]}, 32'h0);
        en = 4'b0111;
        wait_edges(5);                       // e361
        chk("en_on_tick_before", {31'd0, tick[2]}, 32'h0);
        wait_edges(1);                       // e362
        chk("en_on_tick_first", {31'd0, tick[2]}, 32'h1);

        // Reset mid-write discards the staged value
        wait_edges(1);                       // e363
        div_wr = 1'b1; div_sel = 2'd2; div_val = 24'd9;
        wait_edges(1);                       // e364
        div_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tick", {28'd0, tick}, 32'h0);
        chk("rst_async_sq",   {28'd0, sq}, 32'h0);
        chk("rst_async_ack",  {28'd0, div_ack}, 32'h0);
        wait_edges(1);                       // e365
        rst_n = 1'b1;
        acks = 0;
        count_acks(99);                      // e464
        chk("rst_tick_before", {28'd0, tick}, 32'h0);
        count_acks(1);                       // e465
        chk("rst_tick_first", {28'd0, tick}, 32'h7);
        count_acks(1);                       // e466
        chk("rst_no_ack", acks, 32'd0);
        wait_edges(99);                      // e565
        chk("rst_div_default", {28'd0, tick}, 32'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
